id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Operand-issue pipeline register sitting directly upstream of the 16-bit ALU.
- Accepts decoded instructions and register-file read data.
- Resolves operand B: register vs immediate, with extension.
- Applies data forwarding from the ALU's own output and from writeback.
- Presents registered Alu_inputA, Alu_inputB and Alu_control to the ALU under a valid/ready handshake.

Parameters:
DATA_W, 16, datapath width (ALU operand/result width)
REG_ADDR_W, 3, register address width (8 registers, R0 hardwired zero)
CTRL_W, 3, ALU control width (opcodes Add=0 Sub=1 And=2 OR=3 Nor=4 Xor=5 SL=6 SR=7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
In_valid  in  1  decoded instruction present
In_ready  out  1  stage can accept this cycle
Rs_addr, Rt_addr  in  REG_ADDR_W  source register addresses
Rs_data, Rt_data  in  DATA_W  register-file read data
Imm  in  DATA_W/2  8-bit immediate field
Use_imm  in  1  operand B comes from Imm
Alu_op  in  CTRL_W  decoded ALU operation
Rd_addr  in  REG_ADDR_W  destination register
Reg_write  in  1  instruction writes Rd
Flush  in  1  synchronous kill of held instruction
Ex_result  in  DATA_W  combinational ALU result of the instruction currently held here
Wb_valid  in  1  writeback port active
Wb_addr  in  REG_ADDR_W  writeback destination
Wb_data  in  DATA_W  writeback data
Alu_inputA, Alu_inputB  out  DATA_W  registered ALU operands
Alu_control  out  CTRL_W  registered ALU opcode
Out_valid  out  1  held instruction valid
Out_ready  in  1  downstream consumes held instruction
Ex_rd_addr  out  REG_ADDR_W  registered Rd
Ex_reg_write  out  1  registered Reg_write (already gated by valid)

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs are 0.
  - Out_valid=0 and Alu_control=3'b000.
  - In_ready=1 once reset deasserts.
- States: EMPTY (Out_valid=0) and FULL (Out_valid=1).
- Handshake:
  - In_ready = !Out_valid | Out_ready, purely combinational.
  - load = In_valid & In_ready.
- Transitions:
  - EMPTY: load -> FULL.
  - FULL: Out_ready & !load -> EMPTY; Out_ready & load -> FULL with new contents; !Out_ready -> hold all outputs stable.
- Flush has priority over everything:
  - Next cycle Out_valid=0 and Ex_reg_write=0.
  - A coincident load is discarded.
  - Operand registers may keep stale values.
- Latency: one cycle from accepted input to ALU operands; back-to-back throughput is one instruction per cycle.
- Operand A source, first match wins:
  1. Rs_addr==0 -> 0.
  2. Out_valid & Ex_reg_write & Ex_rd_addr==Rs_addr & Out_ready -> Ex_result.
  3. Wb_valid & Wb_addr==Rs_addr -> Wb_data.
  4. Otherwise Rs_data.
- Operand B when Use_imm=0: same priority chain using Rt_addr/Rt_data.
- Operand B when Use_imm=1, by Alu_op:
  - Add/Sub: Imm sign-extended to 16 bits.
  - And/OR/Nor/Xor: Imm zero-extended.
  - SL/SR: {12'b0, Imm[3:0]}, so shift amounts are clamped to 0..15.
- Ex forwarding only applies when the held instruction leaves in the same cycle as the load, which is the only case a load can occur while FULL.
- Ex_reg_write is registered as Reg_write & (Rd_addr!=0). R0 writes are never forwarded and never signalled.
- Wb_addr==0 is never forwarded.
- Outputs never change while FULL & !Out_ready, even if Wb_* changes.
- No arithmetic is performed in this stage; widths are exactly DATA_W with no overflow handling.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (Add..SR).
  - DATA_W, REG_ADDR_W, CTRL_W.
  - Helper function imm_extend(op, imm) implementing the extension rules.
- One natural sub-module, operand_fwd_mux:
  - Combinational priority mux for a single operand.
  - Inputs: addr, rf data, Ex and Wb forward sources.
  - Instantiated twice (A and B).

Test Plan:
- Reset mid-FULL:
  - Stimulus: load Add R1=5,R2=3, then pull rst_n low asynchronously mid-cycle.
  - Required: Out_valid=0 and Alu_inputA/B=0 immediately, without waiting for a clock edge.
- Immediate extension:
  - Stimulus: Use_imm=1, Imm=8'hF0 with Alu_op=Add, then And, then SL.
  - Required: Alu_inputB=16'hFFF0, 16'h00F0, 16'h0000 respectively.
- Ex forwarding:
  - Stimulus: held instr Add Rd=3 with Ex_result=16'h1234 and Out_ready=1; next instr Rs=3 with Rs_data=16'h0000; Wb_valid=1, Wb_addr=3, Wb_data=16'hBEEF.
  - Required: Alu_inputA=16'h1234 (Ex beats Wb).
- R0 rules:
  - Stimulus: Rs_addr=0, Rs_data=16'hFFFF, Wb_addr=0, Wb_data=7; separately a load with Rd=0, Reg_write=1.
  - Required: Alu_inputA=0; Ex_reg_write=0.
- Backpressure:
  - Stimulus: FULL with Out_ready=0 for 3 cycles while In_valid=1 and Wb_data toggles.
  - Required: In_ready=0 and outputs stable; on Out_ready=1 the new instruction loads next cycle with no loss or duplication.
- Flush vs load:
  - Stimulus: Flush=1 with Out_ready=1 and In_valid=1 in the same cycle.
  - Required: next cycle Out_valid=0; the incoming instruction is dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU widths, opcode constants and immediate extension shared by the operand-issue stage.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 3;
  localparam int CTRL_W = 3;
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'd2;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [CTRL_W-1:0] ALU_NOR = 3'd4;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'd5;
  localparam logic [CTRL_W-1:0] ALU_SL  = 3'd6;
  localparam logic [CTRL_W-1:0] ALU_SR  = 3'd7;
  // Arithmetic sign-extends, logic zero-extends, shifts keep only a 0..15 amount.
  function automatic logic [DATA_W-1:0] imm_extend(input logic [CTRL_W-1:0] op,
                                                   input logic [DATA_W/2-1:0] imm);
    return (op == ALU_ADD || op == ALU_SUB) ? {{(DATA_W/2){imm[DATA_W/2-1]}}, imm} :
           (op == ALU_SL || op == ALU_SR)   ? {{(DATA_W-4){1'b0}}, imm[3:0]} :
                                              {{(DATA_W/2){1'b0}}, imm};
  endfunction
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: priority select of one ALU operand (R0, Ex forward, Wb forward, register file).
module operand_fwd_mux
  import alu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     data
);
  always_comb
    data = (addr == '0)                     ? '0 :
           (ex_en && ex_addr == addr)       ? ex_data :
           (wb_valid && wb_addr == addr)    ? wb_data :
                                              rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: operand-issue pipeline register ahead of the 16-bit ALU,
// resolving immediates and forwarding under a valid/ready handshake.
module id_ex_stage
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  In_valid,
  output logic                  In_ready,
  input  logic [REG_ADDR_W-1:0] Rs_addr,
  input  logic [REG_ADDR_W-1:0] Rt_addr,
  input  logic [DATA_W-1:0]     Rs_data,
  input  logic [DATA_W-1:0]     Rt_data,
  input  logic [DATA_W/2-1:0]   Imm,
  input  logic                  Use_imm,
  input  logic [CTRL_W-1:0]     Alu_op,
  input  logic [REG_ADDR_W-1:0] Rd_addr,
  input  logic                  Reg_write,
  input  logic                  Flush,
  input  logic [DATA_W-1:0]     Ex_result,
  input  logic                  Wb_valid,
  input  logic [REG_ADDR_W-1:0] Wb_addr,
  input  logic [DATA_W-1:0]     Wb_data,
  output logic [DATA_W-1:0]     Alu_inputA,
  output logic [DATA_W-1:0]     Alu_inputB,
  output logic [CTRL_W-1:0]     Alu_control,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [REG_ADDR_W-1:0] Ex_rd_addr,
  output logic                  Ex_reg_write
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0] state;
  logic load, ex_en;
  logic [DATA_W-1:0] op_a, rt_val, op_b;
  assign Out_valid = (state == FULL);
  assign In_ready = !Out_valid || Out_ready;
  assign load = In_valid && In_ready;
  // Ex result is only forwardable when the held instruction retires this cycle.
  assign ex_en = Out_valid && Ex_reg_write && Out_ready;
  operand_fwd_mux u_fwd_a (
    .addr(Rs_addr), .rf_data(Rs_data), .ex_en(ex_en), .ex_addr(Ex_rd_addr), .ex_data(Ex_result),
    .wb_valid(Wb_valid), .wb_addr(Wb_addr), .wb_data(Wb_data), .data(op_a)
  );
  operand_fwd_mux u_fwd_b (
    .addr(Rt_addr), .rf_data(Rt_data), .ex_en(ex_en), .ex_addr(Ex_rd_addr), .ex_data(Ex_result),
    .wb_valid(Wb_valid), .wb_addr(Wb_addr), .wb_data(Wb_data), .data(rt_val)
  );
  assign op_b = Use_imm ? imm_extend(Alu_op, Imm) : rt_val;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      Alu_inputA   <= '0;
      Alu_inputB   <= '0;
      Alu_control  <= '0;
      Ex_rd_addr   <= '0;
      Ex_reg_write <= 1'b0;
    end else if (Flush) begin
      state        <= EMPTY;
      Ex_reg_write <= 1'b0;
    end else if (load) begin
      state        <= FULL;
      Alu_inputA   <= op_a;
      Alu_inputB   <= op_b;
      Alu_control  <= Alu_op;
      Ex_rd_addr   <= Rd_addr;
      Ex_reg_write <= Reg_write && (Rd_addr != '0);
    end else if (Out_ready) begin
      state        <= EMPTY;
      Ex_reg_write <= 1'b0;
    end
  end
endmodule
